fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 56 +++++
 rtl/fetch_queue.sv | 100 ++++++++++
 tb/tb_fetch_queue.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and defaults for the instruction fetch queue
package fetch_pkg;

    localparam int          FETCH_DEPTH           = 4;
    localparam int          FETCH_MAX_OUTSTANDING = 2;
    localparam logic [31:0] RESET_PC              = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } fetch_entry_t;

    // Fetch addresses are always whole words.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - entry storage for the fetch queue with flush and occupancy count
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = FETCH_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flush,
    input  logic              i_push,
    input  fetch_entry_t      i_push_data,
    input  logic              i_pop,
    output fetch_entry_t      o_head,
    output logic [CW-1:0]     o_count
);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_push;
    logic w_pop;

    // Flush wins over both push and pop; popping an empty queue is ignored.
    assign w_push = i_push & ~i_flush;
    assign w_pop  = i_pop & ~i_flush & (r_count != '0);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Entry storage needs no reset; the head is only meaningful when count != 0.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch request control and in-order delivery queue
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH           = FETCH_DEPTH,
    parameter int          MAX_OUTSTANDING = FETCH_MAX_OUTSTANDING,
    parameter logic [31:0] RESET_PC        = fetch_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_fault
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [OW-1:0] r_outstanding;
    logic [OW-1:0] r_drop_cnt;

    logic [CW-1:0] w_count;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_data;
    logic [31:0]   w_inflight;
    logic [31:0]   w_new_pc;
    logic          w_fire;
    logic          w_ret;
    logic          w_drop;
    logic          w_accept;
    logic          w_pop;

    // Queue slots already holding or reserved for data must leave room for every response.
    assign w_inflight = 32'(w_count) + 32'(r_outstanding);
    assign mem_req    = rst_n & ~redirect_valid
                      & (w_inflight < 32'(DEPTH))
                      & (32'(r_outstanding) < 32'(MAX_OUTSTANDING));
    assign mem_addr   = r_fetch_pc;

    assign w_new_pc   = word_align(redirect_pc);
    assign w_fire     = mem_req & mem_gnt;
    assign w_ret      = mem_rvalid & (r_outstanding != '0);
    assign w_drop     = w_ret & (r_drop_cnt != '0);
    assign w_accept   = w_ret & (r_drop_cnt == '0) & ~redirect_valid;
    assign w_pop      = out_valid & out_ready & ~redirect_valid;

    assign w_push_data = '{pc: r_resp_pc, instr: mem_rdata, fault: mem_err};

    // Request/response tracking; a redirect reclassifies everything still in flight as stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= r_outstanding + OW'(w_fire) - OW'(w_ret);
            if (redirect_valid) begin
                r_fetch_pc <= w_new_pc;
                r_resp_pc  <= w_new_pc;
                r_drop_cnt <= r_outstanding - OW'(w_ret);
            end else begin
                if (w_fire)   r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_accept) r_resp_pc  <= r_resp_pc + 32'd4;
                if (w_drop)   r_drop_cnt <= r_drop_cnt - OW'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (redirect_valid),
        .i_push      (w_accept),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign out_valid = (w_count != '0);
    assign out_pc    = out_valid ? w_head.pc    : 32'h0;
    assign out_instr = out_valid ? w_head.instr : 32'h0;
    assign out_fault = out_valid & w_head.fault;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized self-checking bench for fetch_queue against a path-level model
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_fault;

    fetch_queue #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO),
        .RESET_PC        (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .mem_err        (mem_err),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_fault      (out_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          ep;
    } pend_t;

    pend_t        pend[$];
    fetch_entry_t mq[$];
    logic [31:0]  exp_fetch;
    int           epoch;
    int           cyc;
    int           checks;
    int           failures;
    int           pops;
    int           gnt_pct, ready_pct, rv_pct, dmin, dmax;
    logic [31:0]  err_addr;
    bit           rand_err;
    bit           got_first;
    logic [31:0]  first_pop;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    function automatic logic fault_of(input logic [31:0] a);
        return (a == err_addr) || (rand_err && (a[7:2] == 6'h2B));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: called at a negedge, drives inputs, checks, updates the model.
    task automatic step(input bit redir, input logic [31:0] rpc);
        bit           present;
        bit           acc;
        bit           exp_req;
        bit           pop;
        pend_t        hd;
        redirect_valid = redir;
        redirect_pc    = rpc;
        out_ready      = ($urandom_range(99) < ready_pct);
        mem_gnt        = ($urandom_range(99) < gnt_pct);
        present = (pend.size() != 0) && (pend[0].due <= cyc) && ($urandom_range(99) < rv_pct);
        if (present) begin
            hd         = pend[0];
            mem_rvalid = 1'b1;
            mem_rdata  = instr_of(hd.addr);
            mem_err    = fault_of(hd.addr);
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            mem_err    = 1'($urandom);
        end
        #1;
        exp_req = !redir && (mq.size() + pend.size() < DEPTH) && (pend.size() < MAXO);
        check("mem_req", 32'(mem_req), 32'(exp_req));
        check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (exp_req) check("mem_addr", mem_addr, exp_fetch);
        pop = (mq.size() != 0) && out_ready && !redir;
        if (pop) begin
            check("out_pc", out_pc, mq[0].pc);
            check("out_instr", out_instr, mq[0].instr);
            check("out_fault", 32'(out_fault), 32'(mq[0].fault));
            pops++;
            if (!got_first) begin
                got_first = 1'b1;
                first_pop = out_pc;
            end
        end
        acc = 1'b0;
        if (present) begin
            hd  = pend.pop_front();
            acc = (hd.ep == epoch) && !redir;
        end
        if (redir) begin
            mq.delete();
            epoch++;
            exp_fetch = {rpc[31:2], 2'b00};
            got_first = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back('{pc: hd.addr, instr: instr_of(hd.addr), fault: fault_of(hd.addr)});
            if (exp_req && mem_gnt) begin
                pend.push_back('{addr: exp_fetch, due: cyc + $urandom_range(dmax, dmin), ep: epoch});
                exp_fetch = exp_fetch + 32'd4;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0);
    endtask

    task automatic knobs(input int g, input int r, input int v, input int lo, input int hi);
        gnt_pct = g; ready_pct = r; rv_pct = v; dmin = lo; dmax = hi;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        redirect_valid = 1'b0;
        mem_gnt        = 1'b0;
        mem_rvalid     = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_fault", 32'(out_fault), 32'h0);
        pend.delete();
        mq.delete();
        epoch++;
        exp_fetch = 32'h0000_0000;
        got_first = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0; out_ready = 1'b0;
        checks = 0; failures = 0; pops = 0; cyc = 0; epoch = 0;
        err_addr = 32'hFFFF_FFF0; rand_err = 1'b0; got_first = 1'b0; first_pop = '0;
        exp_fetch = 32'h0;

        // Streaming with always-ready memory and decode.
        knobs(100, 100, 100, 1, 1);
        do_reset();
        run(20);
        check("stream_pops", 32'(pops >= 12), 32'h1);

        // Decode stall fills the queue and throttles requests.
        knobs(100, 0, 100, 1, 1);
        do_reset();
        run(10);
        #1;
        check("stall_mem_req", 32'(mem_req), 32'h0);
        check("stall_head_pc", out_pc, 32'h0);
        check("stall_out_valid", 32'(out_valid), 32'h1);
        ready_pct = 100;
        run(10);

        // Redirect with stale requests in flight.
        knobs(100, 100, 100, 3, 3);
        do_reset();
        run(4);
        step(1'b1, 32'h0000_0100);
        run(15);
        check("redir_first_pc", first_pop, 32'h0000_0100);

        // Access fault on one word only.
        err_addr = 32'h0000_0008;
        knobs(100, 100, 100, 1, 1);
        do_reset();
        run(15);
        err_addr = 32'hFFFF_FFF0;

        // Unaligned redirect near the top of the address space wraps.
        run(2);
        step(1'b1, 32'hFFFF_FFFE);
        run(12);
        check("wrap_first_pc", first_pop, 32'hFFFF_FFFC);

        // Random traffic with redirects, including back-to-back ones.
        rand_err = 1'b1;
        for (int blk = 0; blk < 30; blk++) begin
            knobs($urandom_range(100, 20), $urandom_range(100, 10), $urandom_range(100, 30), 1, $urandom_range(4, 1));
            for (int i = 0; i < 100; i++) begin
                if ($urandom_range(99) < 5) step(1'b1, $urandom);
                else step(1'b0, 32'h0);
            end
        end

        // Reset in the middle of stalled traffic.
        knobs(100, 0, 100, 3, 3);
        run(6);
        do_reset();
        ready_pct = 100;
        run(12);
        check("post_reset_got", 32'(got_first), 32'h1);
        check("post_reset_pc", first_pop, 32'h0000_0000);
        check("total_pops", 32'(pops > 300), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
